// File: rtl/debounce_calibration_scheduler.sv
// Purpose: sweeps one shared bounce detector over all switch inputs and turns each worst-case settling count into a debounce threshold.
// Latency: CLEAR_CYCLES + MEASURE_WINDOW_CYCLES + 1 cycles per channel; done is high during the final STORE cycle.
// Backpressure: none; start is ignored while busy, abort returns to IDLE next cycle. Optional macro DEBOUNCE_CAL_CONTINUOUS_EN: sweep repeats until abort/reset.
module debounce_calibration_scheduler #(
  parameter int NUM_CHANNELS          = 4,
  parameter int COUNTER_BITS          = 17,
  parameter int MEASURE_WINDOW_CYCLES = 12_000_000,
  parameter int CLEAR_CYCLES          = 4,
  parameter int MARGIN_SHIFT          = 1,
  parameter logic [COUNTER_BITS-1:0] DEFAULT_THRESHOLD = {COUNTER_BITS{1'b1}},
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [NUM_CHANNELS-1:0]              switch_in,
  output logic                                 det_in,
  output logic                                 det_reset,
  input  logic [COUNTER_BITS-1:0]              det_cycles,
  output logic                                 busy,
  output logic                                 done,
  output logic [CH_W-1:0]                      current_channel,
  output logic [NUM_CHANNELS*COUNTER_BITS-1:0] threshold,
  output logic [NUM_CHANNELS-1:0]              threshold_valid
);

  localparam int WIN_W = (MEASURE_WINDOW_CYCLES > 1) ? $clog2(MEASURE_WINDOW_CYCLES) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(MEASURE_WINDOW_CYCLES - 1);
  localparam logic [CLR_W-1:0]        CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [CH_W-1:0]         LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [COUNTER_BITS+1:0] SAT_MAX  = {2'b00, {COUNTER_BITS{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_STORE
  } state_t;

  state_t                  state;
  logic [WIN_W-1:0]        win_cnt;
  logic [CLR_W-1:0]        clr_cnt;
  logic [COUNTER_BITS-1:0] max_reg;
  logic [COUNTER_BITS-1:0] baseline;
  logic [COUNTER_BITS+1:0] sum_ext;
  logic [COUNTER_BITS-1:0] sat_val;

  // The switch under test goes straight to the detector; the channel only
  // moves on STORE->CLEAR, when det_reset is being asserted anyway.
  assign det_in = switch_in[current_channel];

  // Threshold with margin, two guard bits so the add can never wrap before saturating.
  assign sum_ext = {2'b00, max_reg} + {2'b00, max_reg >> MARGIN_SHIFT} + (COUNTER_BITS+2)'(1);
  assign sat_val = (sum_ext > SAT_MAX) ? {COUNTER_BITS{1'b1}} : sum_ext[COUNTER_BITS-1:0];

  // Sweep FSM with registered busy/done/det_reset/channel and the threshold table.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      current_channel <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      det_reset       <= 1'b1;
      threshold       <= {NUM_CHANNELS{DEFAULT_THRESHOLD}};
      threshold_valid <= '0;
      win_cnt         <= '0;
      clr_cnt         <= '0;
      max_reg         <= '0;
      baseline        <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // Abort drops the sweep without writing; finished channels keep their values.
        state     <= S_IDLE;
        busy      <= 1'b0;
        det_reset <= 1'b1;
        win_cnt   <= '0;
        clr_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            det_reset <= 1'b1;
            if (start) begin
              state           <= S_CLEAR;
              current_channel <= '0;
              busy            <= 1'b1;
              clr_cnt         <= '0;
            end
          end
          S_CLEAR: begin
            max_reg <= '0;
            if (clr_cnt == CLR_LAST) begin
              // The detector count may survive its reset, so remember what it
              // reads now and ignore that value during measurement.
              baseline  <= det_cycles;
              clr_cnt   <= '0;
              win_cnt   <= '0;
              det_reset <= 1'b0;
              state     <= S_MEASURE;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          S_MEASURE: begin
            if ((det_cycles != baseline) && (det_cycles > max_reg)) begin
              max_reg <= det_cycles;
            end
            if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              state   <= S_STORE;
              done    <= (current_channel == LAST_CH);
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
            end
          end
          S_STORE: begin
            threshold[int'(current_channel)*COUNTER_BITS +: COUNTER_BITS] <= sat_val;
            threshold_valid[current_channel] <= 1'b1;
            det_reset <= 1'b1;
            clr_cnt   <= '0;
            if (current_channel == LAST_CH) begin
`ifdef DEBOUNCE_CAL_CONTINUOUS_EN
              current_channel <= '0;
              state           <= S_CLEAR;
`else
              busy  <= 1'b0;
              state <= S_IDLE;
`endif
            end else begin
              current_channel <= current_channel + CH_W'(1);
              state           <= S_CLEAR;
            end
          end
          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            det_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
